// File: rtl/key_cfg_ctrl.sv
// Key-driven configuration controller: turns debounced key pulses into shadow-register
// updates and sequences single or burst writes over a valid/ready config bus.
module key_cfg_ctrl #(
    parameter int NUM_REG    = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int VAL_WIDTH  = 8,
    parameter int MAX_VAL    = 255,
    parameter int TMO_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_sel,
    input  logic                  key_up,
    input  logic                  key_down,
    input  logic                  key_apply,
    output logic                  cfg_valid,
    input  logic                  cfg_ready,
    output logic [ADDR_WIDTH-1:0] cfg_addr,
    output logic [VAL_WIDTH-1:0]  cfg_data,
    output logic [ADDR_WIDTH-1:0] cur_sel,
    output logic [VAL_WIDTH-1:0]  cur_val,
    output logic                  busy,
    output logic                  err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_SEL = ADDR_WIDTH'(NUM_REG - 1);
    localparam logic [VAL_WIDTH-1:0]  MAX_V    = VAL_WIDTH'(MAX_VAL);
    // Abort fires on the stalled edge that would take the counter to all-ones.
    localparam logic [TMO_WIDTH-1:0]  TMO_ABORT = {{(TMO_WIDTH-1){1'b1}}, 1'b0};

    state_t                  state;
    state_t                  state_next;
    logic [VAL_WIDTH-1:0]    shadow [NUM_REG];
    logic [TMO_WIDTH-1:0]    tmo_cnt;

    logic [ADDR_WIDTH-1:0]   sel_next;
    logic                    valid_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [VAL_WIDTH-1:0]    data_next;
    logic                    err_next;
    logic [TMO_WIDTH-1:0]    tmo_next;
    logic                    wr_en;
    logic [VAL_WIDTH-1:0]    wr_val;
    logic [ADDR_WIDTH-1:0]   addr_inc;

    assign cur_val  = shadow[cur_sel];
    assign addr_inc = cfg_addr + 1'b1;

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        sel_next   = cur_sel;
        valid_next = cfg_valid;
        addr_next  = cfg_addr;
        data_next  = cfg_data;
        err_next   = 1'b0;
        tmo_next   = tmo_cnt;
        wr_en      = 1'b0;
        wr_val     = '0;

        case (state)
            IDLE: begin
                // One key per cycle: apply > sel > up > down; the rest are discarded.
                if (key_apply) begin
                    state_next = BURST;
                    valid_next = 1'b1;
                    addr_next  = '0;
                    data_next  = shadow[0];
                    tmo_next   = '0;
                end else if (key_sel) begin
                    sel_next = (cur_sel == LAST_SEL) ? '0 : cur_sel + 1'b1;
                end else if (key_up) begin
                    if (cur_val < MAX_V) begin
                        wr_en      = 1'b1;
                        wr_val     = cur_val + 1'b1;
                        state_next = WRITE;
                        valid_next = 1'b1;
                        addr_next  = cur_sel;
                        data_next  = cur_val + 1'b1;
                        tmo_next   = '0;
                    end
                end else if (key_down) begin
                    if (cur_val != '0) begin
                        wr_en      = 1'b1;
                        wr_val     = cur_val - 1'b1;
                        state_next = WRITE;
                        valid_next = 1'b1;
                        addr_next  = cur_sel;
                        data_next  = cur_val - 1'b1;
                        tmo_next   = '0;
                    end
                end
            end

            WRITE, BURST: begin
                if (cfg_ready) begin
                    tmo_next = '0;
                    if (state == BURST && cfg_addr != LAST_SEL) begin
                        addr_next = addr_inc;
                        data_next = shadow[addr_inc];
                    end else begin
                        valid_next = 1'b0;
                        state_next = IDLE;
                    end
                end else begin
                    tmo_next = tmo_cnt + 1'b1;
                    if (tmo_cnt == TMO_ABORT) begin
                        valid_next = 1'b0;
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                valid_next = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur_sel     <= '0;
            cfg_valid   <= 1'b0;
            cfg_addr    <= '0;
            cfg_data    <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            tmo_cnt     <= '0;
            // NOTE: the shadow bank is reset because its contents are visible on
            // cur_val and sent by key_apply; a small register file, not a RAM.
            for (int i = 0; i < NUM_REG; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            state       <= state_next;
            cur_sel     <= sel_next;
            cfg_valid   <= valid_next;
            cfg_addr    <= addr_next;
            cfg_data    <= data_next;
            busy        <= (state_next != IDLE);
            err_timeout <= err_next;
            tmo_cnt     <= tmo_next;
            if (wr_en) begin
                shadow[cur_sel] <= wr_val;
            end
        end
    end

endmodule

// File: tb/tb_key_cfg_ctrl.sv
// Self-checking bench for key_cfg_ctrl: directed scenarios plus randomized key/ready
// traffic, all checked cycle by cycle against a queue-based transaction model.
module tb_key_cfg_ctrl;

    localparam int NUM_REG    = 4;
    localparam int ADDR_WIDTH = 2;
    localparam int VAL_WIDTH  = 8;
    localparam int MAX_VAL    = 255;
    localparam int TMO_WIDTH  = 4;
    localparam int TMO_LIMIT  = (1 << TMO_WIDTH) - 1;

    // Key vector encoding {apply, sel, up, down}.
    localparam logic [3:0] K_NONE = 4'b0000;
    localparam logic [3:0] K_DN   = 4'b0001;
    localparam logic [3:0] K_UP   = 4'b0010;
    localparam logic [3:0] K_SEL  = 4'b0100;
    localparam logic [3:0] K_APP  = 4'b1000;
    localparam bit RDY   = 1'b1;
    localparam bit STALL = 1'b0;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  key_sel = 1'b0;
    logic                  key_up = 1'b0;
    logic                  key_down = 1'b0;
    logic                  key_apply = 1'b0;
    logic                  cfg_valid;
    logic                  cfg_ready = 1'b0;
    logic [ADDR_WIDTH-1:0] cfg_addr;
    logic [VAL_WIDTH-1:0]  cfg_data;
    logic [ADDR_WIDTH-1:0] cur_sel;
    logic [VAL_WIDTH-1:0]  cur_val;
    logic                  busy;
    logic                  err_timeout;

    key_cfg_ctrl #(
        .NUM_REG   (NUM_REG),
        .ADDR_WIDTH(ADDR_WIDTH),
        .VAL_WIDTH (VAL_WIDTH),
        .MAX_VAL   (MAX_VAL),
        .TMO_WIDTH (TMO_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_sel    (key_sel),
        .key_up     (key_up),
        .key_down   (key_down),
        .key_apply  (key_apply),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cur_sel    (cur_sel),
        .cur_val    (cur_val),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: pending write beats live in a queue; busy means non-empty.
    typedef struct {
        int addr;
        int data;
    } beat_t;

    beat_t m_q[$];
    int    m_shadow[NUM_REG];
    int    m_sel;
    int    m_stall;
    int    m_err;

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < NUM_REG; i++) m_shadow[i] = 0;
        m_sel   = 0;
        m_stall = 0;
        m_err   = 0;
    endtask

    task automatic model_step(input logic [3:0] keys, input bit rd);
        beat_t b;
        m_err = 0;
        if (m_q.size() != 0) begin
            if (rd) begin
                m_q.delete(0);
                m_stall = 0;
            end else begin
                m_stall++;
                if (m_stall == TMO_LIMIT) begin
                    m_q.delete();
                    m_err = 1;
                end
            end
        end else if (keys[3]) begin
            for (int i = 0; i < NUM_REG; i++) begin
                b.addr = i;
                b.data = m_shadow[i];
                m_q.push_back(b);
            end
            m_stall = 0;
        end else if (keys[2]) begin
            m_sel = (m_sel + 1) % NUM_REG;
        end else if (keys[1]) begin
            if (m_shadow[m_sel] < MAX_VAL) begin
                m_shadow[m_sel]++;
                b.addr = m_sel;
                b.data = m_shadow[m_sel];
                m_q.push_back(b);
                m_stall = 0;
            end
        end else if (keys[0]) begin
            if (m_shadow[m_sel] > 0) begin
                m_shadow[m_sel]--;
                b.addr = m_sel;
                b.data = m_shadow[m_sel];
                m_q.push_back(b);
                m_stall = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("valid", int'(cfg_valid), int'(m_q.size() > 0));
        check("busy", int'(busy), int'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("addr", int'(cfg_addr), m_q[0].addr);
            check("data", int'(cfg_data), m_q[0].data);
        end
        check("err_timeout", int'(err_timeout), m_err);
        check("cur_sel", int'(cur_sel), m_sel);
        check("cur_val", int'(cur_val), m_shadow[m_sel]);
    endtask

    task automatic step(input logic [3:0] keys, input bit rd);
        key_apply = keys[3];
        key_sel   = keys[2];
        key_up    = keys[1];
        key_down  = keys[0];
        cfg_ready = rd;
        @(posedge clk);
        #1;
        key_apply = 1'b0;
        key_sel   = 1'b0;
        key_up    = 1'b0;
        key_down  = 1'b0;
        model_step(keys, rd);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        compare_all();
    endtask

    initial begin
        int          n_err;
        int          long_stall;
        logic [3:0]  rk;
        bit          rr;

        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        check("rst_valid", int'(cfg_valid), 0);
        check("rst_addr", int'(cfg_addr), 0);
        check("rst_data", int'(cfg_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err_timeout), 0);
        check("rst_sel", int'(cur_sel), 0);

        // Single key_up write, accepted immediately.
        step(K_UP, RDY);
        check("up_valid", int'(cfg_valid), 1);
        check("up_addr", int'(cfg_addr), 0);
        check("up_data", int'(cfg_data), 1);
        check("up_curval", int'(cur_val), 1);
        step(K_NONE, RDY);
        check("up_valid_drop", int'(cfg_valid), 0);
        check("up_busy_drop", int'(busy), 0);

        // Selection wraps after the last register; no writes.
        for (int i = 1; i <= NUM_REG; i++) begin
            step(K_SEL, RDY);
            check("sel_wrap", int'(cur_sel), i % NUM_REG);
            check("sel_no_write", int'(cfg_valid), 0);
        end

        // Saturate register 0 at MAX_VAL, then try to go past it.
        for (int i = 1; i < MAX_VAL; i++) begin
            step(K_UP, RDY);
            step(K_NONE, RDY);
        end
        check("sat_val", int'(cur_val), MAX_VAL);
        step(K_UP, RDY);
        check("sat_no_write", int'(cfg_valid), 0);
        check("sat_hold", int'(cur_val), MAX_VAL);
        step(K_SEL, RDY);
        step(K_DN, RDY);
        check("zero_no_write", int'(cfg_valid), 0);
        check("zero_hold", int'(cur_val), 0);

        // Build shadow = {1,2,3,4}.
        do_reset();
        for (int r = 0; r < NUM_REG; r++) begin
            for (int k = 0; k <= r; k++) begin
                step(K_UP, RDY);
                step(K_NONE, RDY);
            end
            if (r < NUM_REG - 1) step(K_SEL, RDY);
        end

        // Back-to-back burst.
        step(K_APP, RDY);
        for (int i = 0; i < NUM_REG; i++) begin
            check("burst_addr", int'(cfg_addr), i);
            check("burst_data", int'(cfg_data), i + 1);
            step(K_NONE, RDY);
        end
        check("burst_end", int'(cfg_valid), 0);

        // Burst with beat 2 stalled for three cycles.
        step(K_APP, RDY);
        for (int i = 0; i < NUM_REG; i++) begin
            if (i == 2) begin
                for (int s = 0; s < 3; s++) begin
                    step(K_NONE, STALL);
                    check("stall_addr", int'(cfg_addr), 2);
                    check("stall_data", int'(cfg_data), 3);
                end
            end
            check("sburst_addr", int'(cfg_addr), i);
            step(K_NONE, RDY);
        end
        check("sburst_end", int'(cfg_valid), 0);

        // apply + up together: burst only; up while busy is ignored.
        step(K_APP | K_UP, RDY);
        check("prio_burst", int'(cfg_addr), 0);
        check("prio_shadow", int'(cur_val), 4);
        step(K_UP, STALL);
        check("busy_drop_key", int'(cur_val), 4);
        for (int i = 0; i < NUM_REG; i++) step(K_NONE, RDY);
        check("prio_end", int'(cfg_valid), 0);

        // Timeout on a stalled single write.
        step(K_UP, STALL);
        n_err = 0;
        for (int i = 0; i < TMO_LIMIT + 3; i++) begin
            step(K_NONE, STALL);
            if (err_timeout) n_err++;
        end
        check("tmo_pulses", n_err, 1);
        check("tmo_valid", int'(cfg_valid), 0);
        check("tmo_busy", int'(busy), 0);
        check("tmo_shadow_kept", int'(cur_val), 5);
        step(K_UP, RDY);
        check("tmo_recover", int'(cfg_valid), 1);
        check("tmo_recover_data", int'(cfg_data), 6);
        step(K_NONE, RDY);

        // Reset in the middle of a stalled write drops it.
        step(K_UP, STALL);
        step(K_NONE, STALL);
        do_reset();
        check("midrst_valid", int'(cfg_valid), 0);
        step(K_NONE, RDY);
        step(K_NONE, STALL);

        // Randomized traffic, with occasional long stalls to reach the timeout.
        long_stall = 0;
        for (int c = 0; c < 4000; c++) begin
            rk[3] = ($urandom_range(0, 99) < 4);
            rk[2] = ($urandom_range(0, 99) < 12);
            rk[1] = ($urandom_range(0, 99) < 25);
            rk[0] = ($urandom_range(0, 99) < 20);
            if (long_stall == 0 && $urandom_range(0, 199) == 0) long_stall = 20;
            if (long_stall > 0) begin
                rr = 1'b0;
                long_stall--;
            end else begin
                rr = ($urandom_range(0, 99) >= 30);
            end
            step(rk, rr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
